// File: rtl/ms_serial_store.sv
// ms_serial_store
// ---------------------------------------------------------------------------
// Serial main store: LINES lines of WORD_BITS-bit words. Each beat circulates
// one addressed line through a shift register as a bit-serial stream, digit 0
// (LSB) first. The line is either regenerated (its own bits recirculate) or
// rewritten from the serial write-back stream. The assembled word is committed
// to memory at the edge that ends the last digit. A parallel load port can
// preload lines whenever no beat is mid-flight.
//
// Ports
//   w_CLK           digit clock, all state changes on the rising edge
//   w_RST_N         asynchronous active-low reset (clears state and memory)
//   w_BEAT_START    beat request (see handshake note below)
//   w_ADDR          line address, captured with an accepted beat request
//   w_WRITE_EN      1 = rewrite line from w_ITG_DATA_OUT, 0 = regenerate
//   w_ITG_DATA_OUT  serial write-back bit for the current digit
//   w_LOAD_EN       parallel preload strobe
//   w_LOAD_ADDR     preload line address
//   w_LOAD_WORD     preload word, bit 0 = digit 0
//   w_MS_DATA_OUT   serial read bit for the current digit (0 when idle)
//   w_DIGIT         current digit number (0 when idle)
//   w_BUSY          beat in progress; direct decode of the FSM state
//   w_BEAT_END      high during the last digit of a beat
//
// Handshake: there is no ready signal. A beat request (and likewise a load
// strobe) is accepted on a rising edge when the store is idle or in the last
// digit of a beat (w_BEAT_END high); at any other time it is dropped with no
// effect. All outputs come straight from registers.
// ---------------------------------------------------------------------------
module ms_serial_store #(
  parameter int WORD_BITS = 32,
  parameter int LINES     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 w_CLK,
  input  logic                 w_RST_N,
  input  logic                 w_BEAT_START,
  input  logic [ADDR_BITS-1:0] w_ADDR,
  input  logic                 w_WRITE_EN,
  input  logic                 w_ITG_DATA_OUT,
  input  logic                 w_LOAD_EN,
  input  logic [ADDR_BITS-1:0] w_LOAD_ADDR,
  input  logic [WORD_BITS-1:0] w_LOAD_WORD,
  output logic                 w_MS_DATA_OUT,
  output logic [ADDR_BITS-1:0] w_DIGIT,
  output logic                 w_BUSY,
  output logic                 w_BEAT_END
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam logic [ADDR_BITS-1:0] LAST_DIGIT = ADDR_BITS'(WORD_BITS - 1);
  localparam logic [ADDR_BITS-1:0] DIGIT_ONE  = ADDR_BITS'(1);

  // Registers
  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   digit_q, digit_d;
  logic [WORD_BITS-1:0]   shift_q, shift_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   wr_q, wr_d;
  logic [WORD_BITS-1:0]   mem_q [LINES];

  // Decodes
  logic                   last_digit;
  logic                   open_slot;
  logic                   start_ok;
  logic                   load_ok;
  logic                   shift_in;
  logic [WORD_BITS-1:0]   assembled;
  logic [WORD_BITS-1:0]   fetch_word;
  logic                   commit_en;

  always_comb begin
    last_digit = (state_q == ST_ACTIVE) && (digit_q == LAST_DIGIT);
    // Requests are only taken between beats or on the final digit, so a beat
    // in progress can never be disturbed.
    open_slot  = (state_q == ST_IDLE) || last_digit;
    start_ok   = w_BEAT_START && open_slot;
    load_ok    = w_LOAD_EN && open_slot;

    // The bit entering at the top is either the write-back bit or the bit
    // leaving at the bottom, so after WORD_BITS shifts the register holds the
    // rewritten or regenerated word.
    shift_in   = wr_q ? w_ITG_DATA_OUT : shift_q[0];
    assembled  = {shift_in, shift_q[WORD_BITS-1:1]};

    // Word fetched for a newly accepted beat. A same-edge preload has the
    // highest priority (it also wins the memory write below), then the word
    // being committed this edge; memory is stale in both of those cases.
    if (load_ok && (w_LOAD_ADDR == w_ADDR)) begin
      fetch_word = w_LOAD_WORD;
    end else if (last_digit && (addr_q == w_ADDR)) begin
      fetch_word = assembled;
    end else begin
      fetch_word = mem_q[w_ADDR];
    end

    commit_en  = last_digit;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    wr_d    = wr_q;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_ACTIVE;
          digit_d = '0;
          shift_d = fetch_word;
          addr_d  = w_ADDR;
          wr_d    = w_WRITE_EN;
        end
      end

      ST_ACTIVE: begin
        shift_d = assembled;
        digit_d = digit_q + DIGIT_ONE;
        if (last_digit) begin
          if (start_ok) begin
            // Back-to-back beat: stay active and restart at digit 0.
            state_d = ST_ACTIVE;
            digit_d = '0;
            shift_d = fetch_word;
            addr_d  = w_ADDR;
            wr_d    = w_WRITE_EN;
          end else begin
            state_d = ST_IDLE;
            digit_d = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        digit_d = '0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge w_CLK or negedge w_RST_N) begin
    if (!w_RST_N) begin
      state_q <= ST_IDLE;
      digit_q <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
    end
  end

  // Store array. The preload write is placed after the commit so that, when
  // both target the same line on the same edge, the preload word is kept.
  always_ff @(posedge w_CLK or negedge w_RST_N) begin
    if (!w_RST_N) begin
      for (int i = 0; i < LINES; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (commit_en) begin
        mem_q[addr_q] <= assembled;
      end
      if (load_ok) begin
        mem_q[w_LOAD_ADDR] <= w_LOAD_WORD;
      end
    end
  end

  // Outputs, register-derived only
  assign w_BUSY        = (state_q == ST_ACTIVE);
  assign w_MS_DATA_OUT = w_BUSY & shift_q[0];
  assign w_DIGIT       = digit_q;
  assign w_BEAT_END    = last_digit;

endmodule

// File: tb/tb_ms_serial_store.sv
// tb_ms_serial_store
// Directed bench for ms_serial_store. Inputs are driven 1 time unit after a
// rising edge and outputs are sampled at the same point, away from the edge.
module tb_ms_serial_store;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        beat_start;
  logic [4:0]  addr;
  logic        write_en;
  logic        itg;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [31:0] load_word;
  logic        ms_data;
  logic [4:0]  digit;
  logic        busy;
  logic        beat_end;

  int vectors = 0;
  int miscompares = 0;

  ms_serial_store #(.WORD_BITS(32), .LINES(32), .ADDR_BITS(5)) dut (
    .w_CLK          (clk),
    .w_RST_N        (rst_n),
    .w_BEAT_START   (beat_start),
    .w_ADDR         (addr),
    .w_WRITE_EN     (write_en),
    .w_ITG_DATA_OUT (itg),
    .w_LOAD_EN      (load_en),
    .w_LOAD_ADDR    (load_addr),
    .w_LOAD_WORD    (load_word),
    .w_MS_DATA_OUT  (ms_data),
    .w_DIGIT        (digit),
    .w_BUSY         (busy),
    .w_BEAT_END     (beat_end)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] w);
    load_en   = 1'b1;
    load_addr = a;
    load_word = w;
    tick();
    load_en   = 1'b0;
  endtask

  // Request a beat; returns with digit 0 on the outputs.
  task automatic begin_beat(input logic [4:0] a, input logic we);
    beat_start = 1'b1;
    addr       = a;
    write_en   = we;
    tick();
    beat_start = 1'b0;
  endtask

  // Stream one beat starting at digit 0. Optionally pulses w_BEAT_START at
  // digit st_at and w_LOAD_EN at digit ld_at (-1 = none).
  task automatic stream(input logic [31:0] wdata,
                        input int st_at, input logic [4:0] st_addr, input logic st_we,
                        input int ld_at, input logic [4:0] ld_addr, input logic [31:0] ld_word,
                        output logic [31:0] rdata, output int ends, output int end31,
                        output int digit_errs, output int busy_low);
    rdata = '0; ends = 0; end31 = 0; digit_errs = 0; busy_low = 0;
    for (int d = 0; d < 32; d++) begin
      rdata[d] = ms_data;
      if (digit !== 5'(d)) digit_errs++;
      if (beat_end === 1'b1) begin
        ends++;
        if (d == 31) end31 = 1;
      end
      if (busy !== 1'b1) busy_low++;
      itg = wdata[d];
      if (d == st_at) begin
        beat_start = 1'b1;
        addr       = st_addr;
        write_en   = st_we;
      end
      if (d == ld_at) begin
        load_en   = 1'b1;
        load_addr = ld_addr;
        load_word = ld_word;
      end
      tick();
      beat_start = 1'b0;
      load_en    = 1'b0;
    end
  endtask

  // Plain read beat of one line, no side stimulus.
  task automatic read_line(input logic [4:0] a, output logic [31:0] rdata);
    int e, e31, de, bl;
    begin_beat(a, 1'b0);
    stream(32'hFFFF_FFFF, -1, 5'd0, 1'b0, -1, 5'd0, 32'h0, rdata, e, e31, de, bl);
  endtask

  // Stimulus
  initial begin
    logic [31:0] rd;
    int e, e31, de, bl;

    rst_n = 1'b0; beat_start = 1'b0; addr = '0; write_en = 1'b0; itg = 1'b0;
    load_en = 1'b0; load_addr = '0; load_word = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {25'd0, ms_data, digit, busy}, 32'h0);
    check("reset_beat_end", {31'd0, beat_end}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    read_line(5'd0, rd);
    check("line0_after_reset", rd, 32'h0);

    // Preload and read twice
    preload(5'd3, 32'h8000_0001);
    read_line(5'd3, rd);
    check("line3_read1", rd, 32'h8000_0001);
    check("idle_after_beat", {30'd0, busy, ms_data}, 32'h0);
    read_line(5'd3, rd);
    check("line3_read2", rd, 32'h8000_0001);

    // Write beat: odd digits set
    begin_beat(5'd7, 1'b1);
    stream(32'hAAAA_AAAA, -1, 5'd0, 1'b0, -1, 5'd0, 32'h0, rd, e, e31, de, bl);
    check("line7_old", rd, 32'h0);
    check("line7_end_count", 32'(e), 32'd1);
    check("line7_end_at31", 32'(e31), 32'd1);
    check("line7_digits", 32'(de), 32'd0);
    read_line(5'd7, rd);
    check("line7_read", rd, 32'hAAAA_AAAA);

    // Back-to-back forwarding on line 5
    begin_beat(5'd5, 1'b1);
    stream(32'h1234_5678, 31, 5'd5, 1'b0, -1, 5'd0, 32'h0, rd, e, e31, de, bl);
    check("b2b_first", rd, 32'h0);
    check("b2b_first_busy", 32'(bl), 32'd0);
    stream(32'h0000_0000, -1, 5'd0, 1'b0, -1, 5'd0, 32'h0, rd, e, e31, de, bl);
    check("b2b_second", rd, 32'h1234_5678);
    check("b2b_second_busy", 32'(bl), 32'd0);
    check("b2b_second_digits", 32'(de), 32'd0);
    check("b2b_idle_after", {31'd0, busy}, 32'h0);

    // Mid-beat start and load ignored
    preload(5'd2, 32'hFFFF_0000);
    preload(5'd9, 32'h0000_0009);
    begin_beat(5'd2, 1'b0);
    stream(32'h5A5A_5A5A, 10, 5'd9, 1'b1, 5, 5'd2, 32'h1111_1111, rd, e, e31, de, bl);
    check("mid_line2_stream", rd, 32'hFFFF_0000);
    check("mid_digits", 32'(de), 32'd0);
    check("mid_end_count", 32'(e), 32'd1);
    check("mid_idle_after", {31'd0, busy}, 32'h0);
    read_line(5'd2, rd);
    check("mid_line2_after", rd, 32'hFFFF_0000);
    read_line(5'd9, rd);
    check("mid_line9_after", rd, 32'h0000_0009);

    // Load on final digit wins over commit to the same line
    begin_beat(5'd6, 1'b1);
    stream(32'hCAFE_0000, -1, 5'd0, 1'b0, 31, 5'd6, 32'h0BAD_F00D, rd, e, e31, de, bl);
    read_line(5'd6, rd);
    check("load_wins_line6", rd, 32'h0BAD_F00D);

    // Top address
    preload(5'd31, 32'h0F0F_F0F0);
    read_line(5'd31, rd);
    check("line31_read", rd, 32'h0F0F_F0F0);

    // Reset mid-beat
    preload(5'd4, 32'h0000_00FF);
    begin_beat(5'd4, 1'b1);
    itg = 1'b1;
    repeat (15) tick();
    check("rst_digit15", {27'd0, digit}, 32'd15);
    rst_n = 1'b0;
    #1;
    check("rst_outputs", {24'd0, beat_end, ms_data, digit, busy}, 32'h0);
    itg = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_idle", {31'd0, busy}, 32'h0);
    read_line(5'd4, rd);
    check("rst_line4", rd, 32'h0);

    // Load and beat start on the same line, same edge
    load_en    = 1'b1;
    load_addr  = 5'd1;
    load_word  = 32'hDEAD_BEEF;
    beat_start = 1'b1;
    addr       = 5'd1;
    write_en   = 1'b0;
    tick();
    load_en    = 1'b0;
    beat_start = 1'b0;
    stream(32'h0000_0000, -1, 5'd0, 1'b0, -1, 5'd0, 32'h0, rd, e, e31, de, bl);
    check("collide_stream", rd, 32'hDEAD_BEEF);
    read_line(5'd1, rd);
    check("collide_mem", rd, 32'hDEAD_BEEF);

    // Report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ms_serial_store.md
# ms_serial_store

Serial main store for the reduced machine: 32 lines of 32-bit words, each beat circulating one addressed line as a bit-serial stream, LSB (digit 0) first. It is the source of the serial store data consumed by the outward and inward transfer gates. It also accepts the serial write-back stream returned from the inward transfer gate, so each line is either regenerated unchanged or rewritten. A parallel load port lets the bench or typewriter preload lines between beats.

## Interface

- WORD_BITS, 32, digits per beat / bits per store line
- LINES, 32, number of store lines
- ADDR_BITS, 5, line address width; LINES == 2**ADDR_BITS
- w_CLK  input  1  digit clock; all state changes on rising edge
- w_RST_N  input  1  reset, asynchronous, active-low
- w_BEAT_START  input  1  request a beat; sampled on rising edge
- w_ADDR  input  ADDR_BITS  line address, sampled with an accepted w_BEAT_START
- w_WRITE_EN  input  1  1 = rewrite line from w_ITG_DATA_OUT, 0 = regenerate; sampled with an accepted w_BEAT_START
- w_ITG_DATA_OUT  input  1  serial write-back data, one bit per digit
- w_LOAD_EN  input  1  parallel preload strobe
- w_LOAD_ADDR  input  ADDR_BITS  preload line address
- w_LOAD_WORD  input  WORD_BITS  preload data, bit 0 = digit 0
- w_MS_DATA_OUT  output  1  serial read data for the current digit
- w_DIGIT  output  ADDR_BITS  current digit number, 0..WORD_BITS-1
- w_BUSY  output  1  beat in progress
- w_BEAT_END  output  1  high during the last digit of a beat

## Operation

- States: IDLE and ACTIVE.
- IDLE, w_BEAT_START=1 at an edge:
  - latch address and write flag;
  - load shift register from mem[w_ADDR];
  - digit counter to 0; go to ACTIVE.
- ACTIVE, each digit d:
  - w_MS_DATA_OUT = shift[0] = original bit d of the line.
  - At the edge ending digit d, shift right by one. The new MSB is w_ITG_DATA_OUT if writing, else shift[0].
  - Digit counter increments.
- End of beat:
  - The edge ending digit WORD_BITS-1 writes the assembled word to mem[latched address] and returns to IDLE.
  - A regenerate beat leaves the line unchanged.
- w_BEAT_START during ACTIVE digits 0..WORD_BITS-2: ignored, with no effect on the beat in progress.
- w_BEAT_START during digit WORD_BITS-1 (w_BEAT_END high) is accepted back-to-back:
  - the next beat starts at the same edge that commits the write; state stays ACTIVE and the digit counter wraps to 0;
  - same address: the shift register loads the just-assembled word (forwarded), not the stale memory word.
- w_LOAD_EN:
  - honoured only when w_BUSY=0 or during digit WORD_BITS-1;
  - in other ACTIVE digits it is ignored.
- w_LOAD_EN coincident with end-of-beat commit to the same line: load wins.
- w_LOAD_EN and an accepted w_BEAT_START in the same cycle: both act. On the same address, the beat reads w_LOAD_WORD (forwarded).
- Outputs in IDLE: w_MS_DATA_OUT=0, w_DIGIT=0, w_BUSY=0, w_BEAT_END=0.
- Address arithmetic: no wrap beyond LINES-1; the full address space is valid.

## Timing

- Reset (asynchronous, w_RST_N=0):
  - state IDLE, digit 0, shift register 0;
  - all memory lines cleared to 0;
  - all outputs 0.
- Reset during ACTIVE aborts the beat, with no write-back. Operation resumes from the first rising edge after w_RST_N returns to 1.
- w_BEAT_START accepted at edge E:
  - digit 0 is valid on w_MS_DATA_OUT from E until edge E+1 (one-clock latency);
  - digit d is valid between edges E+d and E+d+1.
- w_ITG_DATA_OUT for digit d is sampled at edge E+d+1.
- w_BEAT_END is high between E+31 and E+32. The memory write happens at E+32.
- w_BUSY is high from E through E+32, or continuously across back-to-back beats.
- Beat length is fixed at WORD_BITS clocks. Minimum beat-to-beat spacing is WORD_BITS clocks.
- w_MS_DATA_OUT, w_DIGIT, w_BUSY and w_BEAT_END are all derived from registers only; there is no combinational path from inputs.

## Test plan

- Preload and read: load line 3 = 0x8000_0001 while idle, then regenerate beat at addr 3.
  - Required: w_MS_DATA_OUT=1 at digits 0 and 31, 0 elsewhere.
  - Required: a second read returns the same value.
- Write beat: write addr 7 with w_ITG_DATA_OUT = 1 on odd digits only.
  - Required: a subsequent read of line 7 streams 0xAAAA_AAAA (digit 0 first).
  - Required: w_BEAT_END pulses exactly once, on digit 31.
- Back-to-back forwarding: write 0x1234_5678 to line 5 with w_BEAT_START held high through digit 31, addr 5, read.
  - Required: the second beat streams 0x1234_5678 with no idle cycle; w_BUSY stays 1.
- Mid-beat start ignored: during a read of line 2 (0xFFFF_0000), pulse w_BEAT_START with addr 9 at digit 10.
  - Required: the beat completes on line 2 unchanged; line 9 is not accessed.
  - Required: w_DIGIT continues 11, 12, ... through 31.
- Reset mid-beat: start a write of all-ones to line 4 (preloaded 0x0000_00FF) and assert w_RST_N=0 at digit 15.
  - Required: all outputs 0 immediately.
  - Required: after release, a read of line 4 streams 0.
- Load/beat collision: in IDLE, w_LOAD_EN with line 1 = 0xDEAD_BEEF and w_BEAT_START with addr 1 (read) in the same cycle.
  - Required: the beat streams 0xDEAD_BEEF; memory holds 0xDEAD_BEEF after the beat.
